// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and default widths for the I/D cache memory-port arbiter.
package mem_arb_pkg;
    localparam int ADDR_WIDTH_DEF     = 30;
    localparam int DATA_WIDTH_DEF     = 128;
    localparam int TIMEOUT_CYCLES_DEF = 64;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
    typedef enum logic [1:0] {GNT_NONE, GNT_I, GNT_D} grant_t;
endpackage

// File: rtl/mem_port_arbiter_pick.sv
// Two-way grant select for the memory-port arbiter.
// ROUND_ROBIN_EN adds a last-grant input; otherwise the D-port has fixed priority.
module arb_pick
    import mem_arb_pkg::*;
(
    input  logic   i_req,
    input  logic   d_req,
`ifdef ROUND_ROBIN_EN
    input  logic   last_d,
`endif
    output grant_t pick
);
    always_comb begin
        pick = GNT_NONE;
        if (i_req && d_req) begin
`ifdef ROUND_ROBIN_EN
            pick = last_d ? GNT_I : GNT_D;
`else
            pick = GNT_D;
`endif
        end else if (d_req) begin
            pick = GNT_D;
        end else if (i_req) begin
            pick = GNT_I;
        end
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises I-cache and D-cache block accesses onto one block memory, with a
// sticky watchdog on stuck accesses. Define ROUND_ROBIN_EN for fair arbitration.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH     = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  i_read,
    input  logic [ADDR_WIDTH-1:0] i_address,
    output logic [DATA_WIDTH-1:0] i_readdata,
    output logic                  i_busywait,
    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [ADDR_WIDTH-1:0] d_address,
    input  logic [DATA_WIDTH-1:0] d_writedata,
    output logic [DATA_WIDTH-1:0] d_readdata,
    output logic                  d_busywait,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_writedata,
    input  logic [DATA_WIDTH-1:0] mem_readdata,
    input  logic                  mem_busywait,
    output logic                  timeout_err
);
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state;
    grant_t           grant;
    grant_t           pick;
    logic [CNT_W-1:0] wait_cnt;
    logic             i_req;
    logic             d_req;

    // Simultaneous read and write from the D-cache is illegal and is treated as no request.
    assign i_req = i_read;
    assign d_req = d_read ^ d_write;

    assign i_busywait = i_req && !(state == DONE && grant == GNT_I);
    assign d_busywait = d_req && !(state == DONE && grant == GNT_D);

`ifdef ROUND_ROBIN_EN
    logic last_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            last_d <= 1'b0;
        end else if (state == IDLE && pick != GNT_NONE) begin
            last_d <= (pick == GNT_D);
        end
    end

    arb_pick u_pick (
        .i_req  (i_req),
        .d_req  (d_req),
        .last_d (last_d),
        .pick   (pick)
    );
`else
    arb_pick u_pick (
        .i_req (i_req),
        .d_req (d_req),
        .pick  (pick)
    );
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            grant         <= GNT_NONE;
            wait_cnt      <= '0;
            mem_read      <= 1'b0;
            mem_write     <= 1'b0;
            mem_address   <= '0;
            mem_writedata <= '0;
            i_readdata    <= '0;
            d_readdata    <= '0;
            timeout_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick == GNT_D) begin
                        grant         <= GNT_D;
                        mem_address   <= d_address;
                        mem_writedata <= d_writedata;
                        mem_read      <= d_read;
                        mem_write     <= d_write;
                        state         <= ISSUE;
                    end else if (pick == GNT_I) begin
                        grant         <= GNT_I;
                        mem_address   <= i_address;
                        mem_read      <= 1'b1;
                        mem_write     <= 1'b0;
                        state         <= ISSUE;
                    end
                end
                // Memory accepts the access on this edge; its busywait is not yet meaningful.
                ISSUE: begin
                    wait_cnt <= '0;
                    state    <= WAIT;
                end
                WAIT: begin
                    if (!mem_busywait) begin
                        if (mem_read && grant == GNT_I) begin
                            i_readdata <= mem_readdata;
                        end
                        if (mem_read && grant == GNT_D) begin
                            d_readdata <= mem_readdata;
                        end
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        state     <= DONE;
                    end else if (wait_cnt == CNT_LAST) begin
                        timeout_err <= 1'b1;
                        mem_read    <= 1'b0;
                        mem_write   <= 1'b0;
                        state       <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                DONE: begin
                    grant <= GNT_NONE;
                    state <= IDLE;
                end
                default: begin
                    grant <= GNT_NONE;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: behavioural block memory with
// programmable latency, shadow-memory reference and a transaction-level grant-order model.
module tb_mem_port_arbiter;
    localparam int AW = 30;
    localparam int DW = 128;
    localparam int TO = 8;

    logic          clock = 1'b0;
    logic          reset;
    logic          i_read;
    logic [AW-1:0] i_address;
    logic [DW-1:0] i_readdata;
    logic          i_busywait;
    logic          d_read;
    logic          d_write;
    logic [AW-1:0] d_address;
    logic [DW-1:0] d_writedata;
    logic [DW-1:0] d_readdata;
    logic          d_busywait;
    logic          mem_read;
    logic          mem_write;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_writedata;
    logic [DW-1:0] mem_readdata;
    logic          mem_busywait;
    logic          timeout_err;

    int checks = 0;
    int failures = 0;

    mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clock         (clock),
        .reset         (reset),
        .i_read        (i_read),
        .i_address     (i_address),
        .i_readdata    (i_readdata),
        .i_busywait    (i_busywait),
        .d_read        (d_read),
        .d_write       (d_write),
        .d_address     (d_address),
        .d_writedata   (d_writedata),
        .d_readdata    (d_readdata),
        .d_busywait    (d_busywait),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_address   (mem_address),
        .mem_writedata (mem_writedata),
        .mem_readdata  (mem_readdata),
        .mem_busywait  (mem_busywait),
        .timeout_err   (timeout_err)
    );

    always #5 clock = ~clock;

    function automatic logic [DW-1:0] init_word(input int k);
        logic [31:0] w;
        w = 32'h1111_1111 * k;
        if (k == 0) return {4{32'haabbccdd}};
        return {w, ~w, 32'h0f0f_0f0f ^ w, 32'hc0de_0000 + w};
    endfunction

    // Behavioural block memory: busy for 'lat' cycles of an access, or forever when stuck.
    logic [DW-1:0] mem [16];
    bit            mem_loaded = 1'b0;
    bit            stuck = 1'b0;
    int            lat = 0;
    int            lat_cyc = 0;

    assign mem_busywait = stuck || ((mem_read || mem_write) && lat_cyc < lat);

    always @(posedge clock) begin
        if (reset && !mem_loaded) begin
            for (int k = 0; k < 16; k++) mem[k] <= init_word(k);
            mem_loaded <= 1'b1;
        end else begin
            if (mem_write) mem[mem_address[3:0]] <= mem_writedata;
            if (mem_read) mem_readdata <= mem[mem_address[3:0]];
        end
        lat_cyc <= (mem_read || mem_write) ? lat_cyc + 1 : 0;
    end

    // Grant-order log: address of each access as its strobe rises.
    int  order[$];
    bit  log_en = 1'b0;
    bit  prev_strobe = 1'b0;

    always @(negedge clock) begin
        if (log_en && (mem_read || mem_write) && !prev_strobe) order.push_back(int'(mem_address));
        prev_strobe = mem_read || mem_write;
    end

    // Reference state
    logic [DW-1:0] shadow [16];
    logic [DW-1:0] exp_i_rd;
    logic [DW-1:0] exp_d_rd;

    task automatic apply_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        exp_i_rd = '0;
        exp_d_rd = '0;
    endtask

    // Cache-side driver: request, wait for busywait low (bounded), drop on the DONE edge.
    task automatic access(input bit port_d, input bit wr, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, output logic [DW-1:0] rdata,
                          output int cycles, output int strobe_cyc, output bit proto_ok,
                          output bit other_hi, output bit timed_out);
        cycles = 0; strobe_cyc = 0; proto_ok = 1'b1; other_hi = 1'b0; timed_out = 1'b0; rdata = '0;
        if (port_d) begin
            d_address = addr; d_writedata = wdata; d_read = !wr; d_write = wr;
        end else begin
            i_address = addr; i_read = 1'b1;
        end
        forever begin
            @(negedge clock);
            cycles++;
            if (mem_read && mem_write) proto_ok = 1'b0;
            if (mem_read || mem_write) begin
                strobe_cyc++;
                if (mem_address !== addr || mem_write !== wr || (wr && mem_writedata !== wdata))
                    proto_ok = 1'b0;
            end
            if ((port_d ? i_busywait : d_busywait) !== 1'b0) other_hi = 1'b1;
            if ((port_d ? d_busywait : i_busywait) === 1'b0) begin
                rdata = port_d ? d_readdata : i_readdata;
                break;
            end
            if (cycles >= 200) begin
                timed_out = 1'b1;
                break;
            end
        end
        @(posedge clock);
        #1;
        if (port_d) begin
            d_read = 1'b0; d_write = 1'b0;
        end else begin
            i_read = 1'b0;
        end
    endtask

    task automatic test_reset();
        i_read = 1'b1;
        apply_reset();
        @(negedge clock);
        checks++;
        if (i_busywait !== 1'b1) begin
            failures++; $display("FAIL reset_req_busywait got=%b want=1", i_busywait);
        end
        i_read = 1'b0;
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        checks++;
        if ({mem_read, mem_write, timeout_err, i_busywait, d_busywait} !== 5'b0 ||
            mem_address !== '0 || mem_writedata !== '0 || i_readdata !== '0 || d_readdata !== '0) begin
            failures++;
            $display("FAIL reset_values got rd=%b wr=%b to=%b ib=%b db=%b addr=%h want all zero",
                     mem_read, mem_write, timeout_err, i_busywait, d_busywait, mem_address);
        end
        @(posedge clock);
        #1 reset = 1'b0;
    endtask

    task automatic test_single_i_read();
        logic [DW-1:0] rd; int cyc, sc; bit ok, oh, to;
        access(1'b0, 1'b0, 30'd0, '0, rd, cyc, sc, ok, oh, to);
        exp_i_rd = shadow[0];
        checks++;
        if (rd !== 128'haabbccdd_aabbccdd_aabbccdd_aabbccdd) begin
            failures++; $display("FAIL i_read0_data got=%h want=%h", rd, 128'haabbccdd_aabbccdd_aabbccdd_aabbccdd);
        end
        checks++;
        if (cyc !== 4 || to) begin
            failures++; $display("FAIL i_read0_latency got=%0d want=4", cyc);
        end
        checks++;
        if (sc !== 2 || !ok) begin
            failures++; $display("FAIL i_read0_strobe got cycles=%0d ok=%b want 2/1", sc, ok);
        end
        checks++;
        if (oh) begin
            failures++; $display("FAIL i_read0_d_busywait got=1 want=0");
        end
    endtask

    task automatic test_d_write_read();
        logic [DW-1:0] rd; int cyc, sc; bit ok, oh, to;
        access(1'b1, 1'b1, 30'd5, 128'h1234, rd, cyc, sc, ok, oh, to);
        shadow[5] = 128'h1234;
        checks++;
        if (!ok || sc !== 2 || cyc !== 4) begin
            failures++; $display("FAIL d_write5 got ok=%b strobes=%0d cycles=%0d want 1/2/4", ok, sc, cyc);
        end
        checks++;
        if (d_readdata !== exp_d_rd) begin
            failures++; $display("FAIL d_write5_readdata_hold got=%h want=%h", d_readdata, exp_d_rd);
        end
        access(1'b1, 1'b0, 30'd5, '0, rd, cyc, sc, ok, oh, to);
        exp_d_rd = shadow[5];
        checks++;
        if (rd !== 128'h1234 || !ok || cyc !== 4) begin
            failures++; $display("FAIL d_read5 got data=%h ok=%b cycles=%0d want %h/1/4", rd, ok, cyc, 128'h1234);
        end
    endtask

    task automatic test_simultaneous();
        logic [DW-1:0] rd_i, rd_d; int cyc_i, cyc_d, sc_i, sc_d; bit ok_i, ok_d, oh_i, oh_d, to_i, to_d;
        apply_reset();
        fork
            access(1'b1, 1'b0, 30'd7, '0, rd_d, cyc_d, sc_d, ok_d, oh_d, to_d);
            access(1'b0, 1'b0, 30'd3, '0, rd_i, cyc_i, sc_i, ok_i, oh_i, to_i);
        join
        exp_i_rd = shadow[3];
        exp_d_rd = shadow[7];
        checks++;
        if (cyc_d !== 4 || rd_d !== shadow[7]) begin
            failures++; $display("FAIL simul_d_first got cycles=%0d data=%h want 4/%h", cyc_d, rd_d, shadow[7]);
        end
        checks++;
        if (cyc_i !== 8 || rd_i !== shadow[3]) begin
            failures++; $display("FAIL simul_i_second got cycles=%0d data=%h want 8/%h", cyc_i, rd_i, shadow[3]);
        end
    endtask

    task automatic test_back_to_back();
        int dq[$]; int iq[$]; int exp_order[$]; bit last_d; bit take_d;
        int d_addrs[3]; int i_addrs[3];
        d_addrs = '{8, 9, 10};
        i_addrs = '{11, 12, 13};
        apply_reset();
        order.delete();
        log_en = 1'b1;
        fork
            begin
                logic [DW-1:0] rd; int cyc, sc; bit ok, oh, to;
                for (int k = 0; k < 3; k++) begin
                    access(1'b1, 1'b0, AW'(d_addrs[k]), '0, rd, cyc, sc, ok, oh, to);
                    checks++;
                    if (rd !== shadow[d_addrs[k]] || to) begin
                        failures++; $display("FAIL b2b_d%0d_data got=%h want=%h", k, rd, shadow[d_addrs[k]]);
                    end
                end
            end
            begin
                logic [DW-1:0] rd; int cyc, sc; bit ok, oh, to;
                for (int k = 0; k < 3; k++) begin
                    access(1'b0, 1'b0, AW'(i_addrs[k]), '0, rd, cyc, sc, ok, oh, to);
                    checks++;
                    if (rd !== shadow[i_addrs[k]] || to) begin
                        failures++; $display("FAIL b2b_i%0d_data got=%h want=%h", k, rd, shadow[i_addrs[k]]);
                    end
                end
            end
        join
        log_en = 1'b0;
        exp_d_rd = shadow[10];
        exp_i_rd = shadow[13];
        // Both ports keep a request pending; serve whichever the arbitration rule picks.
        for (int k = 0; k < 3; k++) begin
            dq.push_back(d_addrs[k]);
            iq.push_back(i_addrs[k]);
        end
        last_d = 1'b0;
        while (dq.size() > 0 || iq.size() > 0) begin
            if (dq.size() == 0) take_d = 1'b0;
            else if (iq.size() == 0) take_d = 1'b1;
            else begin
`ifdef ROUND_ROBIN_EN
                take_d = !last_d;
`else
                take_d = 1'b1;
`endif
            end
            exp_order.push_back(take_d ? dq.pop_front() : iq.pop_front());
            last_d = take_d;
        end
        checks++;
        if (order.size() != 6) begin
            failures++; $display("FAIL b2b_count got=%0d want=6", order.size());
        end else begin
            for (int k = 0; k < 6; k++) begin
                checks++;
                if (order[k] != exp_order[k]) begin
                    failures++; $display("FAIL b2b_order%0d got=%0d want=%0d", k, order[k], exp_order[k]);
                end
            end
        end
    endtask

    task automatic test_illegal();
        logic [DW-1:0] rd; int cyc, sc; bit ok, oh, to; bit bad;
        bad = 1'b0;
        d_address = 30'd4; d_read = 1'b1; d_write = 1'b1;
        repeat (4) begin
            @(negedge clock);
            if (d_busywait !== 1'b0 || mem_read !== 1'b0 || mem_write !== 1'b0) bad = 1'b1;
        end
        @(posedge clock);
        #1 d_read = 1'b0; d_write = 1'b0;
        checks++;
        if (bad) begin
            failures++; $display("FAIL illegal_rw got busywait/strobe activity want none");
        end
        access(1'b0, 1'b0, 30'd2, '0, rd, cyc, sc, ok, oh, to);
        exp_i_rd = shadow[2];
        checks++;
        if (cyc !== 4 || rd !== shadow[2]) begin
            failures++; $display("FAIL illegal_then_i got cycles=%0d data=%h want 4/%h", cyc, rd, shadow[2]);
        end
    endtask

    task automatic test_random();
        logic [DW-1:0] rd, wd; int cyc, sc, addr, exp_cyc; bit ok, oh, to, port_d, wr;
        for (int n = 0; n < 24; n++) begin
            port_d = 1'($urandom_range(0, 1));
            wr     = port_d && ($urandom_range(0, 1) == 1);
            addr   = $urandom_range(1, 15);
            wd     = {$urandom, $urandom, $urandom, $urandom};
            lat    = $urandom_range(0, 4);
            exp_cyc = 3 + ((lat < 1) ? 1 : lat);
            access(port_d, wr, AW'(addr), wd, rd, cyc, sc, ok, oh, to);
            checks++;
            if (cyc != exp_cyc || !ok || to) begin
                failures++; $display("FAIL rand%0d_timing got cycles=%0d ok=%b want %0d/1", n, cyc, ok, exp_cyc);
            end
            if (wr) begin
                shadow[addr] = wd;
                checks++;
                if (d_readdata !== exp_d_rd) begin
                    failures++; $display("FAIL rand%0d_d_hold got=%h want=%h", n, d_readdata, exp_d_rd);
                end
            end else begin
                if (port_d) exp_d_rd = shadow[addr]; else exp_i_rd = shadow[addr];
                checks++;
                if (rd !== shadow[addr]) begin
                    failures++; $display("FAIL rand%0d_data got=%h want=%h", n, rd, shadow[addr]);
                end
            end
        end
        lat = 0;
    endtask

    task automatic test_timeout();
        logic [DW-1:0] rd; int cyc, sc; bit ok, oh, to;
        stuck = 1'b1;
        access(1'b0, 1'b0, 30'd6, '0, rd, cyc, sc, ok, oh, to);
        stuck = 1'b0;
        checks++;
        if (to || cyc !== 3 + TO || sc !== 1 + TO) begin
            failures++; $display("FAIL timeout_wait got cycles=%0d strobes=%0d want %0d/%0d", cyc, sc, 3 + TO, 1 + TO);
        end
        checks++;
        if (timeout_err !== 1'b1 || mem_read !== 1'b0 || mem_write !== 1'b0) begin
            failures++; $display("FAIL timeout_flag got err=%b rd=%b wr=%b want 1/0/0", timeout_err, mem_read, mem_write);
        end
        checks++;
        if (rd !== exp_i_rd) begin
            failures++; $display("FAIL timeout_readdata got=%h want=%h", rd, exp_i_rd);
        end
        access(1'b1, 1'b0, 30'd1, '0, rd, cyc, sc, ok, oh, to);
        exp_d_rd = shadow[1];
        checks++;
        if (timeout_err !== 1'b1 || rd !== shadow[1]) begin
            failures++; $display("FAIL timeout_sticky got err=%b data=%h want 1/%h", timeout_err, rd, shadow[1]);
        end
    endtask

    task automatic test_reset_in_wait();
        int cyc;
        stuck = 1'b1;
        i_address = 30'd1;
        i_read = 1'b1;
        repeat (4) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if ({mem_read, mem_write, timeout_err} !== 3'b0 || mem_address !== '0 || mem_writedata !== '0 ||
            i_readdata !== '0 || d_readdata !== '0) begin
            failures++;
            $display("FAIL reset_in_wait got rd=%b wr=%b to=%b addr=%h idata=%h want zeros",
                     mem_read, mem_write, timeout_err, mem_address, i_readdata);
        end
        checks++;
        if (i_busywait !== 1'b1) begin
            failures++; $display("FAIL reset_in_wait_busy got=%b want=1", i_busywait);
        end
        reset = 1'b0;
        stuck = 1'b0;
        cyc = 0;
        do begin
            @(negedge clock);
            cyc++;
        end while (i_busywait !== 1'b0 && cyc < 100);
        checks++;
        if (cyc != 3 || i_readdata !== shadow[1]) begin
            failures++; $display("FAIL reset_rearb got cycles=%0d data=%h want 3/%h", cyc, i_readdata, shadow[1]);
        end
        @(posedge clock);
        #1 i_read = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        i_read = 1'b0; i_address = '0;
        d_read = 1'b0; d_write = 1'b0; d_address = '0; d_writedata = '0;
        for (int k = 0; k < 16; k++) shadow[k] = init_word(k);
        exp_i_rd = '0;
        exp_d_rd = '0;
        test_reset();
        test_single_i_read();
        test_d_write_read();
        test_simultaneous();
        test_back_to_back();
        test_illegal();
        test_random();
        test_timeout();
        test_reset_in_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
